// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. This block holds the program counter, drives the
// combinational instruction ROM, and registers the returned word into the
// IF/ID pipeline register. It also handles stall, flush, branch redirect and
// misaligned-fetch detection.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   stall[5:0]       ctrl stall vector: [0] hold PC, [1] hold IF/ID, [2] ID held
//   flush_i          exception flush: PC <- new_pc_i, IF/ID <- bubble
//   new_pc_i         exception handler address
//   branch_flag_i    taken branch/jump resolved in ID
//   branch_target_i  branch/jump target
//   rom_ce_o         ROM chip enable (low while PC is misaligned or in reset)
//   rom_addr_o       ROM byte address (the current PC)
//   rom_inst_i       ROM read data, same cycle as rom_addr_o
//   id_pc_o          PC of the IF/ID instruction
//   id_inst_o        IF/ID instruction (zero for a bubble or an address error)
//   id_valid_o       IF/ID holds a real fetched slot
//   id_adel_o        IF/ID slot carries an address-error-on-fetch
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_adel_o
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_STEP  = 4;

  // Stall bits above ID belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:3];

  logic            ce_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic            id_valid_q, id_valid_d;
  logic            id_adel_q, id_adel_d;

  logic            aligned;
  logic            hold_pc;
  logic            id_bubble;
  logic            id_hold;

  // Fetch-side decode. All of it comes from registered state only, so the
  // ROM address and enable have no combinational path from the control inputs.
  assign aligned    = (pc_q[1:0] == 2'b00);
  assign rom_addr_o = pc_q;
  assign rom_ce_o   = ce_q & aligned;

  assign hold_pc   = stall[0];
  assign id_bubble = stall[1] & ~stall[2];
  assign id_hold   = stall[1] &  stall[2];

  // PC next-state. The first cycle out of reset re-issues RESET_PC so that
  // the first enabled fetch is RESET_PC. A stall outranks a branch because
  // ID keeps presenting the branch while it is stalled.
  always_comb begin
    pc_d = pc_q;
    if (!ce_q) begin
      pc_d = RESET_PC;
    end else if (flush_i) begin
      pc_d = new_pc_i;
    end else if (hold_pc) begin
      pc_d = pc_q;
    end else if (branch_flag_i) begin
      pc_d = branch_target_i;
    end else begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  // IF/ID next-state. A misaligned PC still produces a valid slot, with the
  // instruction zeroed and adel set, so the exception travels down the pipe.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (flush_i || id_bubble) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (id_hold) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      id_adel_d  = id_adel_q;
    end else begin
      id_pc_d    = pc_q;
      id_inst_d  = rom_ce_o ? rom_inst_i : '0;
      id_valid_d = ce_q;
      id_adel_d  = ce_q & ~aligned;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q       <= 1'b0;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      ce_q       <= 1'b1;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;
  assign id_adel_o  = id_adel_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit with a small combinational ROM model.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_adel_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [64];

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o),
    .id_adel_o       (id_adel_o)
  );

  always #5 clk = ~clk;

  // Word-indexed ROM; it returns data regardless of enable, the DUT must gate it.
  assign rom_inst_i = rom[rom_addr_o[7:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch side: {pc, ce}
  task automatic chk_if(input string name, input logic [31:0] pc, input logic ce);
    checks++;
    if ({rom_addr_o, rom_ce_o} !== {pc, ce}) begin
      failures++;
      $display("FAIL %s: addr=%h ce=%b expected addr=%h ce=%b",
               name, rom_addr_o, rom_ce_o, pc, ce);
    end
  endtask

  // IF/ID side: {pc, inst, valid, adel}
  task automatic chk_id(input string name, input logic [31:0] pc, input logic [31:0] inst,
                        input logic v, input logic a);
    checks++;
    if ({id_pc_o, id_inst_o, id_valid_o, id_adel_o} !== {pc, inst, v, a}) begin
      failures++;
      $display("FAIL %s: id_pc=%h inst=%h v=%b adel=%b expected id_pc=%h inst=%h v=%b adel=%b",
               name, id_pc_o, id_inst_o, id_valid_o, id_adel_o, pc, inst, v, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_if("reset_if", 32'h0, 1'b0);
    chk_id("reset_id", 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_fetch();
    rst = 1'b0;
    tick();
    chk_if("fetch_e0_if", 32'h0, 1'b1);
    chk_id("fetch_e0_id", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_if("fetch_e1_if", 32'h4, 1'b1);
    chk_id("fetch_e1_id", 32'h0, 32'h3401_1100, 1'b1, 1'b0);
    tick();
    chk_if("fetch_e2_if", 32'h8, 1'b1);
    chk_id("fetch_e2_id", 32'h4, 32'h3402_0020, 1'b1, 1'b0);
    tick();
    chk_if("fetch_e3_if", 32'hC, 1'b1);
  endtask

  task automatic test_branch();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h40;
    tick();
    branch_flag_i = 1'b0;
    chk_if("branch_target_if", 32'h40, 1'b1);
    chk_id("branch_delay_slot", 32'hC, 32'h2400_0003, 1'b1, 1'b0);
    tick();
    chk_if("branch_next_if", 32'h44, 1'b1);
    chk_id("branch_target_id", 32'h40, 32'h2400_0010, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h10;
    tick();
    branch_flag_i = 1'b0;
    chk_if("stall_setup_if", 32'h10, 1'b1);
    // Full stall with a competing branch: stall wins, IF/ID holds.
    stall           = 6'b000111;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h80;
    tick();
    branch_flag_i = 1'b0;
    chk_if("stall_hold_branch_if", 32'h10, 1'b1);
    chk_id("stall_hold1_id", 32'h44, 32'h2400_0011, 1'b1, 1'b0);
    tick();
    chk_id("stall_hold2_id", 32'h44, 32'h2400_0011, 1'b1, 1'b0);
    stall = 6'b000011;
    tick();
    chk_if("stall_bubble1_if", 32'h10, 1'b1);
    chk_id("stall_bubble1_id", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_if("stall_bubble2_if", 32'h10, 1'b1);
    chk_id("stall_bubble2_id", 32'h0, 32'h0, 1'b0, 1'b0);
    stall = 6'b000000;
    tick();
    chk_if("stall_resume_if", 32'h14, 1'b1);
    chk_id("stall_resume_id", 32'h10, 32'h2400_0004, 1'b1, 1'b0);
    tick();
    chk_id("stall_resume2_id", 32'h14, 32'h2400_0005, 1'b1, 1'b0);
  endtask

  task automatic test_misaligned();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h42;
    tick();
    branch_flag_i = 1'b0;
    chk_if("misalign_ce_off", 32'h42, 1'b0);
    chk_id("misalign_slot_before", 32'h18, 32'h2400_0006, 1'b1, 1'b0);
    tick();
    chk_if("misalign_advance", 32'h46, 1'b0);
    chk_id("misalign_adel", 32'h42, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_flush();
    flush_i         = 1'b1;
    new_pc_i        = 32'h20;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h80;
    stall           = 6'b000011;
    tick();
    flush_i       = 1'b0;
    branch_flag_i = 1'b0;
    stall         = 6'b000000;
    chk_if("flush_pc", 32'h20, 1'b1);
    chk_id("flush_bubble", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_if("flush_next_pc", 32'h24, 1'b1);
    chk_id("flush_handler_id", 32'h20, 32'h2400_0008, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    flush_i  = 1'b1;
    new_pc_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0;
    chk_if("wrap_top", 32'hFFFF_FFFC, 1'b1);
    tick();
    chk_if("wrap_zero", 32'h0, 1'b1);
    chk_id("wrap_top_id", 32'hFFFF_FFFC, 32'h2400_003F, 1'b1, 1'b0);
    tick();
    chk_id("wrap_zero_id", 32'h0, 32'h3401_1100, 1'b1, 1'b0);
  endtask

  task automatic test_midstream_reset();
    rst = 1'b1;
    tick();
    chk_if("mid_reset_if", 32'h0, 1'b0);
    chk_id("mid_reset_id", 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_if("mid_release_if", 32'h0, 1'b1);
    chk_id("mid_release_id", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_id("mid_first_id", 32'h0, 32'h3401_1100, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h2400_0000 | 32'(i);
    rom[0] = 32'h3401_1100;
    rom[1] = 32'h3402_0020;
    rst             = 1'b1;
    stall           = 6'b000000;
    flush_i         = 1'b0;
    new_pc_i        = 32'h0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;

    test_reset();
    test_fetch();
    test_branch();
    test_stall();
    test_misaligned();
    test_flush();
    test_wrap();
    test_midstream_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
